audio_sample_buffer: RTL
========================

# audio_sample_buffer

Parametrised capture buffer between the audio codec receive path and the feature-extraction front end. On each `new_sample` strobe it takes the 24-bit left/right line-in words, selects or combines channels per `mode`, reduces them to `OUT_W` bits with optional round-and-saturate, and queues them in a `DEPTH`-entry first-word-fall-through FIFO. Data leaves through a valid/ready stream. Overflow is reported as a sticky flag and never stalls the capture path.

## Interface
- `IN_W`, 24, input sample width (two's complement)
- `OUT_W`, 16, output sample width; `OUT_W <= IN_W`
- `DEPTH`, 16, FIFO entries; power of two, >= 4
- `ROUND`, 1, 1 = round-half-up then saturate; 0 = truncate

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `new_sample` in 1: one-cycle strobe; `line_in_l`/`line_in_r` are valid in that cycle.
- `line_in_l` in IN_W: left sample.
- `line_in_r` in IN_W: right sample.
- `mode` in 2: 00 left, 01 right, 10 mono average, 11 stereo interleaved; sampled only on `new_sample`.
- `clr_ovf` in 1: clears `overflow`.
- `out_ready` in 1: downstream accepts.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out OUT_W: FIFO head word.
- `out_chan` out 1: channel tag of head word (0 = L/mono, 1 = R).
- `level` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky drop flag.

## Operation
- Formatting (combinational, on the selected IN_W value x):
  - ROUND=0 gives x[IN_W-1 -: OUT_W].
  - ROUND=1 adds 2^(IN_W-OUT_W-1) in IN_W+1 bits, takes the top OUT_W bits, and saturates positive wrap to 0x7FFF..F. Negatives cannot wrap.
  - IN_W == OUT_W: pass-through.
- Mono: sign-extend L and R to IN_W+1, sum, arithmetic shift right 1 (floor), then format.
- FSM states: IDLE and PUSH_R.
  - IDLE + `new_sample`, modes 00/01/10: if the slot check passes, write one word (tag 0); else drop and set `overflow`.
  - IDLE + `new_sample`, mode 11: if `level <= DEPTH-2` at the strobe cycle, write formatted L (tag 0), latch formatted R, and go to PUSH_R. Otherwise drop both words, set `overflow`, and stay in IDLE. A stereo pair is atomic.
  - PUSH_R: write the latched R (tag 1), then return to IDLE. A `new_sample` arriving in PUSH_R is dropped and sets `overflow`.
- Slot check for single writes:
  - The write is accepted if `level < DEPTH`, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves `level` unchanged.
- Pop: on `out_valid && out_ready`; head advances and `level` decrements.
- Pointers: clog2(DEPTH)-bit, wrapping naturally. `level` is a separate counter, range 0..DEPTH.
- `overflow` is set by any drop and cleared by `clr_ovf`. When a drop and `clr_ovf` occur in the same cycle, set wins.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `level`=0, `overflow`=0.
  - FSM = IDLE, pointers = 0.
- Write latency: a strobe in cycle N writes at the edge ending N. `level` and `out_valid` update in cycle N+1.
- Stereo: L is written at the end of N and R at the end of N+1. With `out_ready`=1 and the FIFO empty, L appears at N+1 and R at N+2, back to back.
- `out_data`/`out_chan` are valid whenever `out_valid`=1 and are held stable until popped.
- `out_valid` never drops without a pop.
- Reset mid-pair (in PUSH_R): everything clears; the pending R word is discarded.

## Test plan
- Formatting, mode 00, ROUND=1:
  - L=0x123480 -> `out_data`=0x1235.
  - L=0x7FFFF0 -> 0x7FFF (saturated).
  - L=0x800000 -> 0x8000.
  - ROUND=0 with L=0x123480 -> 0x1234.
- Mono (mode 10):
  - L=0x000200, R=0x000400 -> 0x0003.
  - L=0xFFFF00, R=0xFFFE00 -> 0xFFFF.
  - Mode 01 with R=0x222200 -> 0x2222.
- Stereo (mode 11), `out_ready`=1, L=0x111100, R=0x222200 -> 0x1111/chan0 at N+1, 0x2222/chan1 at N+2, then `out_valid`=0.
- Overflow (DEPTH=8, `out_ready`=0, mode 00):
  - 9 strobes -> `level`=8, `overflow`=1; draining yields the first 8 samples in order.
  - `level`=7 with a mode-11 strobe -> nothing written, `overflow`=1.
  - `clr_ovf` -> `overflow`=0.
- Full with simultaneous pop: `level`=8, strobe with `out_ready`=1 in the same cycle -> sample accepted, `level` stays 8, `overflow` stays 0.
- Reset during PUSH_R -> next cycle `level`=0, `out_valid`=0; the following strobe behaves as from power-up.

Source files
------------

// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: codec capture, channel select/mono/stereo, round-saturate, FWFT FIFO with sticky overflow
module audio_sample_buffer #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int DEPTH = 16,
    parameter int ROUND = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_sample,
    input  logic [IN_W-1:0]          line_in_l,
    input  logic [IN_W-1:0]          line_in_r,
    input  logic [1:0]               mode,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_chan,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SH = (IN_W > OUT_W) ? IN_W - OUT_W - 1 : 0;
    typedef enum logic {IDLE, PUSH_R} state_t;
    state_t state, state_n;
    logic [OUT_W:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [OUT_W-1:0] fl, fr, fm, r_hold, wdata;
    logic [IN_W-1:0] avg;
    logic push, pop, drop, wchan;

    // Adding the bit just below the kept field equals adding 2^(IN_W-OUT_W-1) before truncation
    function automatic logic [OUT_W-1:0] fmt(input logic [IN_W-1:0] x);
        logic [OUT_W:0] t;
        logic rbit;
        rbit = (IN_W > OUT_W && ROUND != 0) ? x[SH] : 1'b0;
        t = {x[IN_W-1], x[IN_W-1 -: OUT_W]} + (OUT_W+1)'(rbit);
        return (!t[OUT_W] && t[OUT_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}} : t[OUT_W-1:0];
    endfunction

    // floor((l+r)/2) without a wider adder: floor(l/2)+floor(r/2)+carry of the two LSBs
    assign avg = {line_in_l[IN_W-1], line_in_l[IN_W-1:1]} + {line_in_r[IN_W-1], line_in_r[IN_W-1:1]}
               + IN_W'(line_in_l[0] & line_in_r[0]);
    assign fl = fmt(line_in_l);
    assign fr = fmt(line_in_r);
    assign fm = fmt(avg);

    assign out_valid = level != '0;
    assign pop = out_valid && out_ready;
    assign {out_chan, out_data} = out_valid ? mem[rptr] : '0;

    always_comb begin
        push    = 1'b0;
        drop    = 1'b0;
        wdata   = fl;
        wchan   = 1'b0;
        state_n = state;
        if (state == PUSH_R) begin
            push    = 1'b1;
            wdata   = r_hold;
            wchan   = 1'b1;
            drop    = new_sample;
            state_n = IDLE;
        end else if (new_sample) begin
            if (mode == 2'b11) begin
                push    = level <= LW'(DEPTH - 2);
                state_n = push ? PUSH_R : IDLE;
            end else begin
                push  = level < LW'(DEPTH) || pop;
                wdata = mode == 2'b01 ? fr : mode == 2'b10 ? fm : fl;
            end
            drop = !push;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            r_hold   <= '0;
        end else begin
            state    <= state_n;
            wptr     <= wptr + AW'(push);
            rptr     <= rptr + AW'(pop);
            level    <= level + LW'(push) - LW'(pop);
            overflow <= drop | (overflow & ~clr_ovf);
            if (state_n == PUSH_R)
                r_hold <= fr;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {wchan, wdata};
    end
endmodule
